// File: rtl/acc_tx_framer.sv
// Accumulator UART framer: on a rising i_halt edge it sends HEADER, then the
// accumulator bytes LSB first. Define ACC_TX_CHECKSUM_EN to append an XOR checksum byte.
module acc_tx_framer #(
    parameter int              NBITS_D = 16,
    parameter int              DBIT    = 8,
    parameter logic [DBIT-1:0] HEADER  = 8'hA5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic [NBITS_D-1:0] i_acc,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [DBIT-1:0]    o_tx_data,
    output logic               o_busy,
    output logic               o_frame_done
);

    localparam int NACC = NBITS_D / DBIT;
`ifdef ACC_TX_CHECKSUM_EN
    localparam int NBYTES = NACC + 2;
`else
    localparam int NBYTES = NACC + 1;
`endif
    localparam int            IW       = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t             r_state, w_state_next;
    logic               r_halt_q;
    logic [NBITS_D-1:0] r_acc, w_acc_next;
    logic [IW-1:0]      r_idx, w_idx_next, w_idx_inc;
    logic [DBIT-1:0]    r_data, w_data_next, w_next_byte;
    logic               w_trigger;

    assign w_trigger = i_halt & ~r_halt_q;
    assign w_idx_inc = r_idx + IW'(1);
    assign o_tx_data = r_data;

`ifdef ACC_TX_CHECKSUM_EN
    logic [DBIT-1:0] w_csum;

    always_comb begin
        w_csum = HEADER;
        for (int k = 0; k < NACC; k++) begin
            w_csum = w_csum ^ r_acc[k*DBIT +: DBIT];
        end
    end
`endif

    // Byte that follows the one currently on o_tx_data; index 0 is the header.
    always_comb begin
        w_next_byte = '0;
        for (int k = 0; k < NACC; k++) begin
            if (w_idx_inc == IW'(k + 1)) begin
                w_next_byte = r_acc[k*DBIT +: DBIT];
            end
        end
`ifdef ACC_TX_CHECKSUM_EN
        if (w_idx_inc == LAST_IDX) begin
            w_next_byte = w_csum;
        end
`endif
    end

    // NOTE: every output and next-value is defaulted first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_idx_next   = r_idx;
        w_data_next  = r_data;
        o_tx_start   = 1'b0;
        o_busy       = 1'b1;
        o_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (w_trigger) begin
                    w_acc_next   = i_acc;
                    w_idx_next   = '0;
                    w_data_next  = HEADER;
                    w_state_next = START;
                end
            end
            START: begin
                o_tx_start   = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                if (i_tx_done) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_next = DONE;
                    end else begin
                        w_idx_next   = w_idx_inc;
                        w_data_next  = w_next_byte;
                        w_state_next = START;
                    end
                end
            end
            DONE: begin
                o_frame_done = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= IDLE;
            r_halt_q <= 1'b0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_halt_q <= i_halt;
            r_acc    <= w_acc_next;
            r_idx    <= w_idx_next;
            r_data   <= w_data_next;
        end
    end

endmodule

// File: tb/tb_acc_tx_framer.sv
// Self-checking bench for acc_tx_framer: frame-level model plus directed scenarios.
// Define ACC_TX_CHECKSUM_EN for both bench and RTL to test the checksum build.
module tb_acc_tx_framer;

    localparam logic [7:0] HDR  = 8'hA5;
    localparam int         NACC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] acc = '0;
    logic        uart_done = 1'b0;
    logic        stray_done = 1'b0;
    logic        tx_done;
    logic        o_tx_start, o_busy, o_frame_done;
    logic [7:0]  o_tx_data;

    int n_tests = 0;
    int n_fail  = 0;

    assign tx_done = uart_done | stray_done;

    always #5 clk = ~clk;

    acc_tx_framer dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_halt       (halt),
        .i_acc        (acc),
        .i_tx_done    (tx_done),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // uart_tx stand-in: done pulse 10 cycles after each start
    int ucnt = 0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ucnt = 0;
            uart_done = 1'b0;
        end else begin
            uart_done = 1'b0;
            if (o_tx_start) begin
                ucnt = 10;
            end else if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) uart_done = 1'b1;
            end
        end
    end

    // Frame-level model: bytes still to load, plus which phase of the byte handshake we are in.
    logic       m_hq = 1'b0, m_start = 1'b0, m_wait = 1'b0, m_done = 1'b0, m_trig;
    logic [7:0] m_cur = '0, m_cs;
    logic [7:0] m_frame[$];
    int         m_frames = 0;
    logic       m_busy;
    assign m_busy = m_start | m_wait | m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hq = 1'b0; m_start = 1'b0; m_wait = 1'b0; m_done = 1'b0; m_cur = '0;
            m_frame.delete();
        end else begin
            m_trig = halt && !m_hq;
            m_hq = halt;
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_start) begin
                m_start = 1'b0;
                m_wait = 1'b1;
            end else if (m_wait) begin
                if (tx_done) begin
                    m_wait = 1'b0;
                    if (m_frame.size() == 0) m_done = 1'b1;
                    else begin
                        m_cur = m_frame.pop_front();
                        m_start = 1'b1;
                    end
                end
            end else if (m_trig) begin
                m_cs = HDR;
                for (int k = 0; k < NACC; k++) begin
                    m_frame.push_back(acc[k*8 +: 8]);
                    m_cs = m_cs ^ acc[k*8 +: 8];
                end
`ifdef ACC_TX_CHECKSUM_EN
                m_frame.push_back(m_cs);
`endif
                m_cur = HDR;
                m_start = 1'b1;
                m_frames++;
            end
        end
    end

    logic done_prev_edge = 1'b0;
    always @(posedge clk) done_prev_edge <= tx_done;

    logic [7:0] sent[$];

    always @(negedge clk) begin
        check("busy", o_busy, m_busy);
        check("tx_start", o_tx_start, m_start);
        check("tx_data", o_tx_data, m_cur);
        check("frame_done", o_frame_done, m_done);
        if (o_frame_done) check("frame_done_follows_tx_done", done_prev_edge, 1);
        if (o_tx_start) sent.push_back(o_tx_data);
    end

    task automatic wait_quiet(input int max);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((o_busy || m_busy) && n < max);
        check("frame_end_within_bound", o_busy || m_busy, 0);
    endtask

    task automatic check_frame(input string name, input logic [7:0] e[$]);
        check({name, "_len"}, sent.size(), e.size());
        for (int i = 0; i < e.size() && i < sent.size(); i++)
            check($sformatf("%s_byte%0d", name, i), sent[i], e[i]);
    endtask

    logic [7:0] exp_q[$];
    int f0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx_start", o_tx_start, 0);
        check("rst_tx_data", o_tx_data, 0);
        check("rst_busy", o_busy, 0);
        check("rst_frame_done", o_frame_done, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame
        acc = 16'h1234; sent.delete(); f0 = m_frames; halt = 1'b1;
        wait_quiet(200);
        exp_q = {8'hA5, 8'h34, 8'h12};
`ifdef ACC_TX_CHECKSUM_EN
        exp_q.push_back(8'h83);
`endif
        check_frame("basic", exp_q);
        check("basic_frames", m_frames - f0, 1);
        halt = 1'b0;
        repeat (3) @(negedge clk);

        // Held-high halt gives one frame; re-arm with 00FF
        f0 = m_frames; sent.delete(); halt = 1'b1;
        repeat (200) @(negedge clk);
        check("held_frames", m_frames - f0, 1);
        check("held_starts", sent.size(), exp_q.size());
        wait_quiet(200);
        halt = 1'b0;
        @(negedge clk);
        acc = 16'h00FF; sent.delete(); halt = 1'b1;
        wait_quiet(200);
        exp_q = {8'hA5, 8'hFF, 8'h00};
`ifdef ACC_TX_CHECKSUM_EN
        exp_q.push_back(8'h5A);
`endif
        check_frame("rearm", exp_q);
        halt = 1'b0;
        repeat (3) @(negedge clk);

        // Second halt pulse and acc change during a frame
        acc = 16'h1234; sent.delete(); f0 = m_frames; halt = 1'b1;
        repeat (5) @(negedge clk);
        halt = 1'b0; acc = 16'hBEEF;
        repeat (3) @(negedge clk);
        halt = 1'b1;
        repeat (3) @(negedge clk);
        halt = 1'b0;
        wait_quiet(200);
        repeat (10) @(negedge clk);
        exp_q = {8'hA5, 8'h34, 8'h12};
`ifdef ACC_TX_CHECKSUM_EN
        exp_q.push_back(8'h83);
`endif
        check_frame("midframe", exp_q);
        check("midframe_frames", m_frames - f0, 1);

        // Stray done in IDLE, then in START
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        check("stray_idle_busy", o_busy, 0);
        repeat (2) @(negedge clk);
        acc = 16'h1234; sent.delete(); halt = 1'b1;
        @(negedge clk);
        check("stray_start_seen", o_tx_start, 1);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0; halt = 1'b0;
        wait_quiet(200);
        check_frame("stray_start", exp_q);

        // Reset while waiting for tx_done
        acc = 16'h5678; sent.delete(); halt = 1'b1;
        repeat (4) @(negedge clk);
        halt = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("wait_rst_tx_start", o_tx_start, 0);
        check("wait_rst_tx_data", o_tx_data, 0);
        check("wait_rst_busy", o_busy, 0);
        check("wait_rst_frame_done", o_frame_done, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("wait_rst_starts", sent.size(), 1);

        // halt high at reset release triggers a frame
        @(posedge clk); #2 rst_n = 1'b0; halt = 1'b1;
        repeat (2) @(negedge clk);
        sent.delete();
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        check("release_first_cycle_start", o_tx_start, 0);
        @(negedge clk);
        check("release_start", o_tx_start, 1);
        check("release_header", o_tx_data, 8'hA5);
        halt = 1'b0;
        wait_quiet(200);
        check("release_frames_bytes", sent.size(), exp_q.size());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/acc_tx_framer.md
ACC_TX_FRAMER -- requirements
Module: acc_tx_framer

Interface
REQ-001 Parameter NBITS_D, default 16: accumulator width in bits; SHALL be a multiple of DBIT, minimum DBIT.
REQ-002 Parameter DBIT, default 8: UART data byte width.
REQ-003 Parameter HEADER, default 8'hA5: frame start byte.
REQ-004 Port i_clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 Port i_reset  input  1: reset, asynchronous and active-low.
REQ-006 Port i_halt  input  1: processor halt level, driven by the BIP.
REQ-007 Port i_acc  input  NBITS_D: processor accumulator value.
REQ-008 Port i_tx_done  input  1: one-cycle pulse from uart_tx when a byte has finished transmitting.
REQ-009 Port o_tx_start  output  1: one-cycle pulse requesting uart_tx to send o_tx_data.
REQ-010 Port o_tx_data  output  DBIT: byte presented to uart_tx.
REQ-011 Port o_busy  output  1: high while a frame is in progress.
REQ-012 Port o_frame_done  output  1: one-cycle pulse after the last byte's i_tx_done.

Function
REQ-013 The block SHALL register i_halt into halt_q each cycle; a trigger is the cycle where i_halt=1 and halt_q=0.
REQ-014 The FSM SHALL have states IDLE, START, WAIT and DONE.
REQ-015 IDLE: on a trigger, the block SHALL capture i_acc into acc_q, set the byte index to 0, load o_tx_data=HEADER and go to START.
REQ-016 START: the block SHALL assert o_tx_start for exactly this one cycle, then go to WAIT; the first o_tx_start therefore occurs the cycle after the trigger.
REQ-017 WAIT: the block SHALL hold o_tx_data stable until i_tx_done=1; i_tx_done SHALL be ignored in every other state.
REQ-018 WAIT with i_tx_done and bytes remaining: the block SHALL load the next byte into o_tx_data and go to START.
REQ-019 Frame byte order SHALL be HEADER, then NBITS_D/DBIT accumulator bytes least-significant first, then the optional checksum (REQ-028).
REQ-020 WAIT with i_tx_done on the last byte: the block SHALL go to DONE; DONE SHALL assert o_frame_done for one cycle, then return to IDLE.
REQ-021 o_busy SHALL be 1 in START, WAIT and DONE, and 0 in IDLE.
REQ-022 A trigger while not in IDLE SHALL be ignored and not queued; i_acc changes after capture SHALL NOT affect the frame.
REQ-023 The trigger is edge-based: a continuously high i_halt SHALL produce exactly one frame; a new frame requires i_halt to fall and rise again.
REQ-024 A trigger in the same cycle that DONE returns to IDLE SHALL be ignored, because the FSM is not yet in IDLE; halt_q still updates.

Reset
REQ-025 While i_reset=0, the block SHALL force: state=IDLE, o_tx_start=0, o_tx_data=0, o_busy=0, o_frame_done=0, halt_q=0, acc_q=0, byte index=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no further o_tx_start pulses.
REQ-027 Because halt_q resets to 0, i_halt=1 on the first clock after reset release SHALL count as a trigger.

Configuration
REQ-028 With macro ACC_TX_CHECKSUM_EN defined, the block SHALL append one byte equal to the XOR of HEADER and all accumulator bytes; without it, the frame SHALL end after the last accumulator byte and no checksum logic SHALL exist.

Verification
REQ-029 Both builds SHALL run these scenarios with a uart_tx model that pulses i_tx_done 10 cycles after each o_tx_start:
- Macro off; i_acc=16'h1234, i_halt rises -> bytes A5, 34, 12; o_frame_done one cycle after the third i_tx_done; o_busy falls with it.
- Macro on; same stimulus -> bytes A5, 34, 12, 83.
- i_halt held high for 200 cycles -> exactly one frame; lower and raise it with i_acc=16'h00FF -> second frame A5, FF, 00.
- Second i_halt pulse during the frame, and i_acc changed to 16'hBEEF mid-frame -> no extra frame; bytes still 34, 12.
- Stray i_tx_done while in IDLE or START -> no state change; reset pulled low while in WAIT -> all outputs 0 on that edge and no further o_tx_start.
- i_halt=1 at reset release -> o_tx_start carrying HEADER two cycles after release.
